// File: rtl/frame_buffer_port_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_port_if
// Description : SDRAM write/read FIFO handshake bundle for frame_buffer_port.
//               master = frame buffer port side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buffer_port_if;
  logic       wr_fifo_wrreq;
  logic [7:0] wr_fifo_data;
  logic       wr_fifo_full;
  logic       rd_fifo_rdreq;
  logic [7:0] rd_fifo_q;
  logic       rd_fifo_empty;

  modport master (
    output wr_fifo_wrreq,
    output wr_fifo_data,
    input  wr_fifo_full,
    output rd_fifo_rdreq,
    input  rd_fifo_q,
    input  rd_fifo_empty
  );

  modport slave (
    input  wr_fifo_wrreq,
    input  wr_fifo_data,
    output wr_fifo_full,
    input  rd_fifo_rdreq,
    output rd_fifo_q,
    output rd_fifo_empty
  );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_port.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_port
// Description : Streams current-frame luma into the SDRAM write FIFO and
//               returns the previous frame's luma from the read FIFO, aligned
//               one cycle after each pixel strobe. Tracks frame length and
//               FIFO overflow/underflow in sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_port #(
  parameter int IMG_H = 640,
  parameter int IMG_V = 480
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst_n,
  input  wire logic        per_frame_vsync,
  input  wire logic        per_frame_href,
  input  wire logic        per_frame_clken,
  input  wire logic [7:0]  per_img_Y,
  frame_buffer_port_if.master fifo,
  output logic             frame_sync,
  output logic [7:0]       YCbCr_img_Y_pre,
  output logic             pre_frame_valid,
  output logic [2:0]       err_flags
);

  // IDLE: no frame reference yet; FIRST: writing the first frame only;
  // STREAM: writing the current frame while reading back the previous one.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam logic [19:0] c_frame_pixels = 20'(IMG_H * IMG_V);

  logic [1:0]  r_state;
  logic        r_vsync_d;
  logic        r_rd_ack;
  logic        r_frame_sync;
  logic [19:0] r_pix_cnt;
  logic [2:0]  r_err;

  logic        w_vsync_edge;
  logic        w_pixel;
  logic        w_active;
  logic        w_stream;
  logic        w_wr;
  logic        w_rd;
  logic [19:0] w_cnt_next;

  assign w_vsync_edge = per_frame_vsync & ~r_vsync_d;
  assign w_pixel      = per_frame_clken & per_frame_href;
  assign w_active     = (r_state == S_FIRST) || (r_state == S_STREAM);
  assign w_stream     = (r_state == S_STREAM);
  assign w_wr         = w_active & w_pixel & ~fifo.wr_fifo_full;
  assign w_rd         = w_stream & w_pixel & ~fifo.rd_fifo_empty;
  // A pixel coinciding with the vsync edge still belongs to the ending frame.
  assign w_cnt_next   = r_pix_cnt + {19'd0, w_active & w_pixel};

  assign fifo.wr_fifo_wrreq = w_wr;
  assign fifo.wr_fifo_data  = per_img_Y;
  assign fifo.rd_fifo_rdreq = w_rd;

  assign frame_sync      = r_frame_sync;
  assign YCbCr_img_Y_pre = r_rd_ack ? fifo.rd_fifo_q : 8'd0;
  assign pre_frame_valid = w_stream;
  assign err_flags       = r_err;

  // Frame-level state: needs two vsync edges before a previous frame exists.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else if (w_vsync_edge) begin
      case (r_state)
        S_IDLE:  r_state <= S_FIRST;
        S_FIRST: r_state <= S_STREAM;
        default: r_state <= S_STREAM;
      endcase
    end
  end

  // Vsync edge detection, frame_sync pulse and read-data alignment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vsync_d    <= 1'b0;
      r_frame_sync <= 1'b0;
      r_rd_ack     <= 1'b0;
    end else begin
      r_vsync_d    <= per_frame_vsync;
      r_frame_sync <= w_vsync_edge;
      r_rd_ack     <= w_rd;
    end
  end

  // Pixel counter for the frame-length check, cleared at every frame boundary.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_cnt <= 20'd0;
    end else if (w_vsync_edge) begin
      r_pix_cnt <= 20'd0;
    end else begin
      r_pix_cnt <= w_cnt_next;
    end
  end

  // Sticky error flags {frame_len_err, rd_underflow, wr_overflow}.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_err <= 3'b000;
    end else begin
      if (w_active & w_pixel & fifo.wr_fifo_full)
        r_err[0] <= 1'b1;
      if (w_stream & w_pixel & fifo.rd_fifo_empty)
        r_err[1] <= 1'b1;
      if (w_vsync_edge & w_active & (w_cnt_next != c_frame_pixels))
        r_err[2] <= 1'b1;
    end
  end

endmodule
`default_nettype wire
